// File: rtl/proto245s_deframer_pkg.sv
// Shared types and constants for the proto245s RX deframer.
//   byte_t      : 8-bit data byte
//   state_t     : deframer FSM states (HUNT, LEN, PAYLOAD, CSUM)
//   SOF_DEFAULT : default start-of-frame marker
package proto245s_deframer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  localparam byte_t SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/proto245s_skid2.sv
// Two-entry valid/ready output buffer carrying {last, data}.
// Entry 0 is always the head, so the output fields come straight from
// registers and stay stable while the head waits for pop_ready_i.
//   clk_i, rst_ni           : clock, async active-low reset
//   push_i/push_data_i/
//   push_last_i             : write side (ignored when full without a pop)
//   pop_ready_i             : downstream ready
//   pop_valid_o/pop_data_o/
//   pop_last_o              : head entry
//   count_o                 : number of held entries (0..2)
module proto245s_skid2
  import proto245s_deframer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  byte_t      push_data_i,
  input  logic       push_last_i,
  input  logic       pop_ready_i,
  output logic       pop_valid_o,
  output byte_t      pop_data_o,
  output logic       pop_last_o,
  output logic [1:0] count_o
);

  logic [1:0] count_q, count_d;
  byte_t      data0_q, data0_d, data1_q, data1_d;
  logic       last0_q, last0_d, last1_q, last1_d;
  logic       valid_q, valid_d;
  logic       pop_s, push_s;

  // Next-state for the two entries: shift toward the head on pop.
  always_comb begin
    pop_s   = valid_q & pop_ready_i;
    push_s  = push_i & ((count_q != 2'd2) | pop_s);
    count_d = count_q;
    data0_d = data0_q;
    last0_d = last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    case ({push_s, pop_s})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = push_data_i;
          last0_d = push_last_i;
        end else begin
          data1_d = push_data_i;
          last1_d = push_last_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          data0_d = push_data_i;
          last0_d = push_last_i;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = push_data_i;
          last1_d = push_last_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      valid_q <= 1'b0;
      data0_q <= 8'h00;
      last0_q <= 1'b0;
      data1_q <= 8'h00;
      last1_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      data0_q <= data0_d;
      last0_q <= last0_d;
      data1_q <= data1_d;
      last1_q <= last1_d;
    end
  end

  assign pop_valid_o = valid_q;
  assign pop_data_o  = data0_q;
  assign pop_last_o  = last0_q;
  assign count_o     = count_q;

endmodule

// File: rtl/proto245s_rx_deframer.sv
// proto245s RX deframer: reads the RX FIFO, hunts for SOF | LEN | PAYLOAD | CSUM
// frames, streams the payload over valid/ready and reports checksum status.
//   fifo_clk, fifo_rstn        : clock, async active-low reset
//   rxfifo_rd/data/valid/empty : RX FIFO read port (data 1 cycle after rd)
//   m_data/m_valid/m_ready/
//   m_last                     : payload stream
//   stat_ok/stat_err           : 1-cycle frame status pulses
//   frame_cnt/err_cnt/drop_cnt : saturating statistics
module proto245s_rx_deframer
  import proto245s_deframer_pkg::*;
#(
  parameter byte_t SOF_BYTE = SOF_DEFAULT,
  parameter int    MAX_LEN  = 255,
  parameter int    CNT_W    = 16
) (
  input  logic             fifo_clk,
  input  logic             fifo_rstn,
  output logic             rxfifo_rd,
  input  logic [7:0]       rxfifo_data,
  input  logic             rxfifo_valid,
  input  logic             rxfifo_empty,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             stat_ok,
  output logic             stat_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  // Compared in 9 bits so the range test stays meaningful when MAX_LEN is 255.
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t           state_q;
  byte_t            sum_q;
  byte_t            remaining_q;
  logic             inflight_q;
  logic             stat_ok_q, stat_err_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, drop_cnt_q;

  logic [1:0] buf_count_s;
  logic [1:0] occ_s;
  logic       buf_pop_s;
  logic       rd_s;
  logic       push_s;
  logic       push_last_s;
  logic       len_ok_s;
  byte_t      csum_s;

  // Read budget: buffer occupancy after this cycle's pop plus the byte in flight.
  // Counting the pop keeps 1 byte/cycle streaming while m_ready stays high.
  always_comb begin
    buf_pop_s   = m_valid & m_ready;
    occ_s       = buf_count_s - {1'b0, buf_pop_s} + {1'b0, inflight_q};
    rd_s        = ~rxfifo_empty & (occ_s < 2'd2);
    push_s      = rxfifo_valid & (state_q == PAYLOAD);
    push_last_s = (remaining_q == 8'd1);
    len_ok_s    = (rxfifo_data != 8'd0) & ({1'b0, rxfifo_data} <= MAX_LEN_W);
    csum_s      = sum_q + rxfifo_data;
  end

  // rd must react to rxfifo_empty in the same cycle, so it is not registered.
  assign rxfifo_rd = rd_s;

  // Frame FSM, running checksum, status pulses and statistics counters.
  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      state_q     <= HUNT;
      sum_q       <= 8'h00;
      remaining_q <= 8'h00;
      inflight_q  <= 1'b0;
      stat_ok_q   <= 1'b0;
      stat_err_q  <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q   <= {CNT_W{1'b0}};
      drop_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      inflight_q <= rd_s;
      stat_ok_q  <= 1'b0;
      stat_err_q <= 1'b0;
      if (rxfifo_valid) begin
        case (state_q)
          HUNT: begin
            if (rxfifo_data == SOF_BYTE) begin
              state_q <= LEN;
            end else begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end
          end
          LEN: begin
            if (len_ok_s) begin
              sum_q       <= rxfifo_data;
              remaining_q <= rxfifo_data;
              state_q     <= PAYLOAD;
            end else begin
              stat_err_q <= 1'b1;
              err_cnt_q  <= sat_inc(err_cnt_q);
              state_q    <= HUNT;
            end
          end
          PAYLOAD: begin
            sum_q       <= csum_s;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_q <= CSUM;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          CSUM: begin
            if (csum_s == 8'h00) begin
              stat_ok_q   <= 1'b1;
              frame_cnt_q <= sat_inc(frame_cnt_q);
            end else begin
              stat_err_q <= 1'b1;
              err_cnt_q  <= sat_inc(err_cnt_q);
            end
            state_q <= HUNT;
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  proto245s_skid2 u_skid (
    .clk_i       (fifo_clk),
    .rst_ni      (fifo_rstn),
    .push_i      (push_s),
    .push_data_i (rxfifo_data),
    .push_last_i (push_last_s),
    .pop_ready_i (m_ready),
    .pop_valid_o (m_valid),
    .pop_data_o  (m_data),
    .pop_last_o  (m_last),
    .count_o     (buf_count_s)
  );

  assign stat_ok   = stat_ok_q;
  assign stat_err  = stat_err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_proto245s_rx_deframer.sv
// Directed testbench for proto245s_rx_deframer with a behavioural RX FIFO.
module tb_proto245s_rx_deframer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxfifo_rd;
  logic [7:0]  rxfifo_data;
  logic        rxfifo_valid;
  logic        rxfifo_empty;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        stat_ok;
  logic        stat_err;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  proto245s_rx_deframer dut (
    .fifo_clk     (clk),
    .fifo_rstn    (rst_n),
    .rxfifo_rd    (rxfifo_rd),
    .rxfifo_data  (rxfifo_data),
    .rxfifo_valid (rxfifo_valid),
    .rxfifo_empty (rxfifo_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .stat_ok      (stat_ok),
    .stat_err     (stat_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .drop_cnt     (drop_cnt)
  );

  // RX FIFO model: data and valid one cycle after an accepted read.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rxfifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxfifo_valid <= 1'b0;
      rxfifo_data  <= 8'h00;
    end else if (rxfifo_rd && (rd_ptr != wr_ptr)) begin
      rxfifo_data  <= mem[rd_ptr];
      rxfifo_valid <= 1'b1;
      rd_ptr       <= rd_ptr + 1;
    end else begin
      rxfifo_valid <= 1'b0;
    end
  end

  // Downstream ready: fixed level or random per cycle.
  logic rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Monitor on the falling edge: collected beats, pulses, protocol observations.
  logic [7:0] got_data [$];
  logic       got_last [$];
  int ok_cnt = 0, err_pulse = 0, both_cnt = 0, rd_empty_viol = 0;
  int rd_acc = 0, pop_acc = 0, occ_max = 0;
  logic occ_en = 1'b0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
    end
    if (stat_ok) ok_cnt++;
    if (stat_err) err_pulse++;
    if (stat_ok && stat_err) both_cnt++;
    if (rxfifo_rd && rxfifo_empty) rd_empty_viol++;
    if (!occ_en) begin
      rd_acc = 0; pop_acc = 0; occ_max = 0;
    end else begin
      if (rd_acc - pop_acc - 2 > occ_max) occ_max = rd_acc - pop_acc - 2;
      rd_acc  += int'(rxfifo_rd);
      pop_acc += int'(m_valid && m_ready);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Loads n bytes from w, most significant byte first.
  task automatic load_bytes(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) push_byte(w[8*(n-1-i) +: 8]);
  endtask

  // Checks n beats since index base against w (MSB first); last only on the final one.
  task automatic check_beats(input string tag, input int base, input logic [63:0] w, input int n);
    check_val({tag, "_nbeats"}, got_data.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < got_data.size()) begin
        check_val({tag, "_data"}, got_data[base+i], w[8*(n-1-i) +: 8]);
        check_val({tag, "_last"}, got_last[base+i], (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  int base, ok0, err0, mism, nlast;
  logic [7:0] s8;

  initial begin
    rst_n = 1'b0;
    wait_cyc(3);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_stat", {stat_ok, stat_err}, 0);
    check_val("rst_counters", {frame_cnt, err_cnt} | drop_cnt, 0);
    check_val("rst_rd", rxfifo_rd, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // 1: good 3-byte frame
    base = got_data.size(); ok0 = ok_cnt; err0 = err_pulse;
    load_bytes(64'h0000_A503_1122_3397, 6);
    wait_cyc(30);
    check_beats("t1", base, 64'h0000_0000_0011_2233, 3);
    check_val("t1_ok", ok_cnt - ok0, 1);
    check_val("t1_err", err_pulse - err0, 0);
    check_val("t1_frame_cnt", frame_cnt, 1);

    // 2: bad checksum, payload still forwarded
    base = got_data.size(); ok0 = ok_cnt; err0 = err_pulse;
    load_bytes(64'h0000_A503_1122_3396, 6);
    wait_cyc(30);
    check_beats("t2", base, 64'h0000_0000_0011_2233, 3);
    check_val("t2_ok", ok_cnt - ok0, 0);
    check_val("t2_err", err_pulse - err0, 1);
    check_val("t2_err_cnt", err_cnt, 1);
    check_val("t2_frame_cnt", frame_cnt, 1);

    // 3: garbage before SOF, SOF value as checksum
    base = got_data.size(); ok0 = ok_cnt;
    load_bytes(64'h0000_00FF_A501_5AA5, 6);
    wait_cyc(30);
    check_val("t3_drop_cnt", drop_cnt, 2);
    check_beats("t3", base, 64'h0000_0000_0000_005A, 1);
    check_val("t3_ok", ok_cnt - ok0, 1);
    check_val("t3_frame_cnt", frame_cnt, 2);

    // 4: LEN=0 then a good frame
    base = got_data.size(); ok0 = ok_cnt; err0 = err_pulse;
    load_bytes(64'h0000_0000_0000_A500, 2);
    load_bytes(64'h0000_A503_1122_3397, 6);
    wait_cyc(40);
    check_beats("t4", base, 64'h0000_0000_0011_2233, 3);
    check_val("t4_err", err_pulse - err0, 1);
    check_val("t4_ok", ok_cnt - ok0, 1);
    check_val("t4_err_cnt", err_cnt, 2);
    check_val("t4_frame_cnt", frame_cnt, 3);
    check_val("t4_drop_cnt", drop_cnt, 2);

    // 5: 255-byte frame with random backpressure
    base = got_data.size(); ok0 = ok_cnt;
    occ_en = 1'b1;
    rdy_rand = 1'b1;
    s8 = 8'hFF;
    push_byte(8'hA5);
    push_byte(8'hFF);
    for (int i = 0; i < 255; i++) begin
      push_byte(8'(i));
      s8 = s8 + 8'(i);
    end
    push_byte(8'h00 - s8);
    wait_cyc(1500);
    rdy_rand = 1'b0;
    occ_en = 1'b0;
    check_val("t5_nbeats", got_data.size() - base, 255);
    mism = 0; nlast = 0;
    for (int i = 0; i < 255; i++) begin
      if (base + i < got_data.size()) begin
        if (got_data[base+i] !== 8'(i)) mism++;
        if (got_last[base+i] !== (i == 254)) mism++;
        if (got_last[base+i] === 1'b1) nlast++;
      end
    end
    check_val("t5_order_last", mism, 0);
    check_val("t5_nlast", nlast, 1);
    check_val("t5_ok", ok_cnt - ok0, 1);
    check_val("t5_frame_cnt", frame_cnt, 4);
    check_val("t5_occ_max_le2", (occ_max <= 2) ? 1 : 0, 1);
    check_val("rd_when_empty", rd_empty_viol, 0);

    // 6: reset mid-frame with beats waiting in the buffer
    rdy_fix = 1'b0;
    wait_cyc(2);
    load_bytes(64'h0000_0000_A505_0102, 4);
    wait_cyc(20);
    check_val("t6_pre_valid", m_valid, 1);
    check_val("t6_pre_data", m_data, 8'h01);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", m_valid, 0);
    check_val("t6_rst_data_last", {m_data, m_last}, 0);
    check_val("t6_rst_stat", {stat_ok, stat_err}, 0);
    check_val("t6_rst_counters", {frame_cnt, err_cnt} | drop_cnt, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    rdy_fix = 1'b1;
    wait_cyc(2);
    base = got_data.size(); ok0 = ok_cnt;
    load_bytes(64'h0000_0000_A501_10EF, 4);
    wait_cyc(30);
    check_beats("t6", base, 64'h0000_0000_0000_0010, 1);
    check_val("t6_ok", ok_cnt - ok0, 1);
    check_val("t6_frame_cnt", frame_cnt, 1);

    check_val("ok_err_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
